// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: sample sequencer and double-buffered coefficient manager for
// the 32-tap FIR datapath. One sample in flight at a time; host coefficient
// writes land in a shadow bank that is copied to the active bank between samples.
// Build option: define FIR_SEQ_STATS_EN to add stat_samples / stat_timeouts.
module fir_seq_ctrl #(
   parameter int NTAPS    = 32,
   parameter int SAMPLE_W = 16,
   parameter int COEFF_W  = 17,
   parameter int TIMEOUT  = 15
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [SAMPLE_W-1:0]        in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [SAMPLE_W-1:0]        out_data,
   output logic                       fir_run,
   input  logic                       fir_busy,
   output logic [SAMPLE_W-1:0]        fir_sample,
   input  logic [SAMPLE_W-1:0]        fir_result,
   output logic [NTAPS*COEFF_W-1:0]   fir_coeff,
   input  logic                       cfg_we,
   input  logic [$clog2(NTAPS)-1:0]   cfg_addr,
   input  logic [COEFF_W-1:0]         cfg_data,
   input  logic                       cfg_commit,
   output logic                       cfg_pending,
   output logic                       err_timeout
`ifdef FIR_SEQ_STATS_EN
   ,
   output logic [31:0]                stat_samples,
   output logic [15:0]                stat_timeouts
`endif
);

   localparam int AW = $clog2(NTAPS);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SWAP,
      S_ISSUE,
      S_WAIT,
      S_OUTPUT
   } state_t;

   state_t             state, state_nx;
   logic [TW-1:0]      timer;
   logic [COEFF_W-1:0] shadow [NTAPS];
   logic [COEFF_W-1:0] active [NTAPS];
   logic               accept_in;
   logic               capture;
   logic               abort;
   logic               timer_max;

   assign timer_max = (timer == TW'(TIMEOUT));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state decode and per-state control strobes.
   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      fir_run   = 1'b0;
      accept_in = 1'b0;
      capture   = 1'b0;
      abort     = 1'b0;
      case (state)
         S_IDLE: begin
            if (cfg_pending) begin
               state_nx = S_SWAP;
            end else begin
               in_ready = rst_n;
               if (in_valid && rst_n) begin
                  accept_in = 1'b1;
                  state_nx  = S_ISSUE;
               end
            end
         end
         S_SWAP:  state_nx = S_IDLE;
         S_ISSUE: begin
            fir_run  = 1'b1;
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (!fir_busy) begin
               capture  = 1'b1;
               state_nx = S_OUTPUT;
            end else if (timer_max) begin
               abort    = 1'b1;
               state_nx = S_IDLE;
            end
         end
         S_OUTPUT: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Sample latch, result capture, busy timer and sticky timeout flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fir_sample  <= '0;
         out_data    <= '0;
         timer       <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (accept_in) fir_sample <= in_data;
         if (state == S_ISSUE)                timer <= '0;
         else if (state == S_WAIT && !timer_max) timer <= timer + TW'(1);
         if (capture) out_data <= fir_result;
         if (abort)   err_timeout <= 1'b1;
      end
   end

   // Coefficient banks: shadow takes host writes at any time; active changes only in SWAP.
   // Non-blocking copy means a write in the SWAP cycle misses this swap, and a
   // commit in that cycle re-arms pending so a second swap picks it up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < NTAPS; k++) begin
            shadow[k] <= '0;
            active[k] <= '0;
         end
         cfg_pending <= 1'b0;
      end else begin
         if (cfg_we && ({1'b0, cfg_addr} < (AW+1)'(NTAPS))) shadow[cfg_addr] <= cfg_data;
         if (state == S_SWAP) begin
            for (int unsigned k = 0; k < NTAPS; k++) active[k] <= shadow[k];
            cfg_pending <= cfg_commit;
         end else if (cfg_commit) begin
            cfg_pending <= 1'b1;
         end
      end
   end

   // Flatten the active bank onto the FIR coefficient bus.
   always_comb begin
      fir_coeff = '0;
      for (int unsigned k = 0; k < NTAPS; k++) fir_coeff[k*COEFF_W +: COEFF_W] = active[k];
   end

`ifdef FIR_SEQ_STATS_EN
   // Output-handshake counter (wrapping) and timeout-abort counter (saturating).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_samples  <= '0;
         stat_timeouts <= '0;
      end else begin
         if (out_valid && out_ready) stat_samples <= stat_samples + 32'd1;
         if (abort && stat_timeouts != 16'hFFFF) stat_timeouts <= stat_timeouts + 16'd1;
      end
   end
`else
   // No statistics counters in this build.
`endif

endmodule
